// File: rtl/sdram_stream_arbiter_pkg.sv
// Shared definitions for the SDRAM stream path: burst scheduler FSM states,
// grant encodings and default burst/FIFO geometry used by the FIFO controllers.
package sdram_stream_pkg;

    localparam int unsigned DEF_BURST_LEN  = 256;
    localparam int unsigned DEF_FIFO_DEPTH = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        RD_CMD  = 3'd2,
        WR_BUSY = 3'd3,
        RD_BUSY = 3'd4
    } arb_state_t;

    localparam logic GRANT_WR = 1'b1;
    localparam logic GRANT_RD = 1'b0;

endpackage

// File: rtl/sdram_stream_arbiter_if.sv
// Burst command port between the stream arbiter (master) and the SDRAM controller (slave).
interface sdram_stream_arbiter_if #(
    parameter int unsigned ADDR_W = 22
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic              burst_done;

    modport master (
        output cmd_valid,
        output cmd_wr,
        output cmd_addr,
        input  cmd_ready,
        input  burst_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_wr,
        input  cmd_addr,
        output cmd_ready,
        output burst_done
    );

endinterface

// File: rtl/sdram_stream_arbiter_ring_ptr.sv
// Wrapping ring pointer: advances by one burst per strobe, wraps at 2**ADDR_W.
module sdram_ring_ptr
    import sdram_stream_pkg::*;
#(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [ADDR_W-1:0] ptr
);

    // Bursts are aligned and divide the ring, so natural overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr + ADDR_W'(BURST_LEN);
        end
    end

endmodule

// File: rtl/sdram_stream_arbiter.sv
// SDRAM burst scheduler for the stream path. Shares the controller command port
// between ingress drain (write bursts) and egress refill (read bursts), and
// tracks the SDRAM as a circular buffer of whole bursts.
// Optional feature macro: SDRAM_STREAM_WR_URGENT_EN (urgent ingress priority).
module sdram_stream_arbiter
    import sdram_stream_pkg::*;
#(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned USEDW_W    = 10,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
`ifdef SDRAM_STREAM_WR_URGENT_EN
   ,parameter int unsigned URGENT_LVL = 768
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [USEDW_W-1:0]   wr_usedw,
    input  logic [USEDW_W-1:0]   rd_usedw,
    sdram_stream_arbiter_if.master cmd,
    output logic [ADDR_W:0]      ring_words,
    output logic                 ring_full,
    output logic                 ring_empty,
    output logic                 err_spurious
);

    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam logic [CMP_W-1:0] RING_SIZE = CMP_W'(1) << ADDR_W;
    localparam logic [CMP_W-1:0] BURST_W   = CMP_W'(BURST_LEN);
    localparam logic [CMP_W-1:0] DEPTH_W   = CMP_W'(FIFO_DEPTH);

    arb_state_t        state, state_n;
    logic              last_grant, last_grant_n;
    logic              cmd_valid_q, cmd_valid_n;
    logic              cmd_wr_q, cmd_wr_n;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_n;
    logic [ADDR_W:0]   ring_words_n;
    logic              err_spurious_n;
    logic              wr_adv_c, rd_adv_c;
    logic              wr_elig_c, rd_elig_c, wr_first_c;
    logic [CMP_W-1:0]  wr_fill_c, rd_fill_c;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;

    sdram_ring_ptr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .adv (wr_adv_c),
        .ptr (wr_ptr)
    );

    sdram_ring_ptr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .adv (rd_adv_c),
        .ptr (rd_ptr)
    );

    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_wr    = cmd_wr_q;
    assign cmd.cmd_addr  = cmd_addr_q;

    // Eligibility: a whole burst of data and a whole burst of space on each side.
    always_comb begin
        wr_fill_c = CMP_W'(wr_usedw);
        rd_fill_c = CMP_W'(rd_usedw);
        wr_elig_c = (wr_fill_c >= BURST_W) && ((RING_SIZE - ring_words) >= BURST_W);
        rd_elig_c = (ring_words >= BURST_W) && ((DEPTH_W - rd_fill_c) >= BURST_W);
`ifdef SDRAM_STREAM_WR_URGENT_EN
        wr_first_c = (last_grant == GRANT_RD) || (wr_fill_c >= CMP_W'(URGENT_LVL));
`else
        wr_first_c = (last_grant == GRANT_RD);
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GRANT_RD;
            cmd_valid_q  <= 1'b0;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            ring_words   <= '0;
            ring_full    <= 1'b0;
            ring_empty   <= 1'b1;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_n;
            last_grant   <= last_grant_n;
            cmd_valid_q  <= cmd_valid_n;
            cmd_wr_q     <= cmd_wr_n;
            cmd_addr_q   <= cmd_addr_n;
            ring_words   <= ring_words_n;
            ring_full    <= (ring_words_n == RING_SIZE);
            ring_empty   <= (ring_words_n == '0);
            err_spurious <= err_spurious_n;
        end
    end

    // Next-state, command outputs, pointer strobes and occupancy.
    always_comb begin
        state_n        = state;
        last_grant_n   = last_grant;
        cmd_valid_n    = cmd_valid_q;
        cmd_wr_n       = cmd_wr_q;
        cmd_addr_n     = cmd_addr_q;
        ring_words_n   = ring_words;
        err_spurious_n = err_spurious;
        wr_adv_c       = 1'b0;
        rd_adv_c       = 1'b0;

        case (state)
            IDLE: begin
                if (wr_elig_c && (!rd_elig_c || wr_first_c)) begin
                    state_n     = WR_CMD;
                    cmd_valid_n = 1'b1;
                    cmd_wr_n    = 1'b1;
                    cmd_addr_n  = wr_ptr;
                end else if (rd_elig_c) begin
                    state_n     = RD_CMD;
                    cmd_valid_n = 1'b1;
                    cmd_wr_n    = 1'b0;
                    cmd_addr_n  = rd_ptr;
                end
            end
            WR_CMD: begin
                if (cmd.cmd_ready) begin
                    state_n     = WR_BUSY;
                    cmd_valid_n = 1'b0;
                end
            end
            RD_CMD: begin
                if (cmd.cmd_ready) begin
                    state_n     = RD_BUSY;
                    cmd_valid_n = 1'b0;
                end
            end
            WR_BUSY: begin
                if (cmd.burst_done) begin
                    state_n      = IDLE;
                    wr_adv_c     = 1'b1;
                    ring_words_n = ring_words + BURST_W;
                    last_grant_n = GRANT_WR;
                end
            end
            RD_BUSY: begin
                if (cmd.burst_done) begin
                    state_n      = IDLE;
                    rd_adv_c     = 1'b1;
                    ring_words_n = ring_words - BURST_W;
                    last_grant_n = GRANT_RD;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A completion with no accepted burst outstanding is a controller fault.
        if (cmd.burst_done && (state == IDLE || state == WR_CMD || state == RD_CMD)) begin
            err_spurious_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_stream_arbiter.sv
// Directed bench for sdram_stream_arbiter on a 4-burst ring (ADDR_W=10).
module tb_sdram_stream_arbiter;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic [9:0]        wr_usedw;
    logic [9:0]        rd_usedw;
    logic [ADDR_W:0]   ring_words;
    logic              ring_full;
    logic              ring_empty;
    logic              err_spurious;

    int checks   = 0;
    int failures = 0;

    sdram_stream_arbiter_if #(.ADDR_W(ADDR_W)) cmd_if ();

    sdram_stream_arbiter #(
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (256),
        .USEDW_W    (10),
        .FIFO_DEPTH (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_usedw     (wr_usedw),
        .rd_usedw     (rd_usedw),
        .cmd          (cmd_if.master),
        .ring_words   (ring_words),
        .ring_full    (ring_full),
        .ring_empty   (ring_empty),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let IDLE sample once, accept the command, then complete the burst.
    task automatic grant_burst(output logic v, output logic w, output logic [ADDR_W-1:0] a,
                               output logic v_after);
        tick();
        v = cmd_if.cmd_valid;
        w = cmd_if.cmd_wr;
        a = cmd_if.cmd_addr;
        cmd_if.cmd_ready = 1'b1;
        tick();
        v_after = cmd_if.cmd_valid;
        cmd_if.cmd_ready  = 1'b0;
        cmd_if.burst_done = 1'b1;
        tick();
        cmd_if.burst_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_usedw = '0;
        rd_usedw = '0;
        cmd_if.cmd_ready  = 1'b0;
        cmd_if.burst_done = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_if.cmd_valid); end
        checks++; if (cmd_if.cmd_wr !== 1'b0) begin failures++; $display("FAIL reset_cmd_wr got=%0b exp=0", cmd_if.cmd_wr); end
        checks++; if (cmd_if.cmd_addr !== 10'd0) begin failures++; $display("FAIL reset_cmd_addr got=%0d exp=0", cmd_if.cmd_addr); end
        checks++; if (ring_words !== 11'd0) begin failures++; $display("FAIL reset_ring_words got=%0d exp=0", ring_words); end
        checks++; if (ring_empty !== 1'b1 || ring_full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", ring_empty, ring_full); end
        checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_spurious); end
        rst = 1'b0;
    endtask

    task automatic test_first_write();
        logic v, w, va;
        logic [ADDR_W-1:0] a;
        wr_usedw = 10'd256;
        rd_usedw = 10'd0;
        grant_burst(v, w, a, va);
        wr_usedw = 10'd0;
        checks++; if (v !== 1'b1 || w !== 1'b1 || a !== 10'd0) begin failures++; $display("FAIL first_write_cmd got v=%0b wr=%0b addr=%0d exp v=1 wr=1 addr=0", v, w, a); end
        checks++; if (va !== 1'b0) begin failures++; $display("FAIL first_write_drop got=%0b exp=0", va); end
        checks++; if (ring_words !== 11'd256 || ring_empty !== 1'b0) begin failures++; $display("FAIL first_write_ring got words=%0d empty=%0b exp words=256 empty=0", ring_words, ring_empty); end
    endtask

    // Round-robin sequence from ring=256, last grant WR, wr_ptr=256, rd_ptr=0.
    task automatic test_round_robin();
        logic [9:0]  wu [7] = '{10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd0};
        logic [9:0]  ru [7] = '{10'd0, 10'd1000, 10'd1000, 10'd0, 10'd0, 10'd0, 10'd0};
        logic        ew [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0]  ea [7] = '{10'd0, 10'd256, 10'd512, 10'd256, 10'd768, 10'd512, 10'd768};
        logic [10:0] er [7] = '{11'd0, 11'd256, 11'd512, 11'd256, 11'd512, 11'd256, 11'd0};
        logic v, w, va;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 7; i++) begin
            wr_usedw = wu[i];
            rd_usedw = ru[i];
            grant_burst(v, w, a, va);
            checks++; if (v !== 1'b1 || w !== ew[i] || a !== ea[i]) begin failures++; $display("FAIL rr_grant[%0d] got v=%0b wr=%0b addr=%0d exp v=1 wr=%0b addr=%0d", i, v, w, a, ew[i], ea[i]); end
            checks++; if (ring_words !== er[i]) begin failures++; $display("FAIL rr_ring[%0d] got=%0d exp=%0d", i, ring_words, er[i]); end
        end
        wr_usedw = 10'd0;
        rd_usedw = 10'd0;
    endtask

    task automatic test_stall();
        wr_usedw = 10'd256;
        rd_usedw = 10'd0;
        cmd_if.cmd_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_wr !== 1'b1 || cmd_if.cmd_addr !== 10'd0) begin failures++; $display("FAIL stall_hold[%0d] got v=%0b wr=%0b addr=%0d exp v=1 wr=1 addr=0", i, cmd_if.cmd_valid, cmd_if.cmd_wr, cmd_if.cmd_addr); end
            tick();
        end
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
        checks++; if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL stall_drop got=%0b exp=0", cmd_if.cmd_valid); end
        cmd_if.burst_done = 1'b1;
        tick();
        cmd_if.burst_done = 1'b0;
        wr_usedw = 10'd0;
        checks++; if (ring_words !== 11'd256) begin failures++; $display("FAIL stall_ring got=%0d exp=256", ring_words); end
    endtask

    task automatic test_wrap_full();
        logic v, w, va;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] exp_a;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_a = ADDR_W'((i * 256) % 1024);
            wr_usedw = 10'd256;
            rd_usedw = 10'd0;
            grant_burst(v, w, a, va);
            checks++; if (v !== 1'b1 || w !== 1'b1 || a !== exp_a) begin failures++; $display("FAIL wrap_wr[%0d] got v=%0b wr=%0b addr=%0d exp v=1 wr=1 addr=%0d", i, v, w, a, exp_a); end
            wr_usedw = 10'd0;
            grant_burst(v, w, a, va);
            checks++; if (v !== 1'b1 || w !== 1'b0 || a !== exp_a) begin failures++; $display("FAIL wrap_rd[%0d] got v=%0b wr=%0b addr=%0d exp v=1 wr=0 addr=%0d", i, v, w, a, exp_a); end
        end
        rd_usedw = 10'd1000;
        for (int k = 0; k < 4; k++) begin
            exp_a = ADDR_W'(((k + 1) * 256) % 1024);
            wr_usedw = 10'd256;
            grant_burst(v, w, a, va);
            checks++; if (v !== 1'b1 || w !== 1'b1 || a !== exp_a) begin failures++; $display("FAIL fill_wr[%0d] got v=%0b wr=%0b addr=%0d exp v=1 wr=1 addr=%0d", k, v, w, a, exp_a); end
        end
        checks++; if (ring_words !== 11'd1024 || ring_full !== 1'b1 || ring_empty !== 1'b0) begin failures++; $display("FAIL fill_flags got words=%0d full=%0b empty=%0b exp words=1024 full=1 empty=0", ring_words, ring_full, ring_empty); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL full_blocks_wr[%0d] got=%0b exp=0", i, cmd_if.cmd_valid); end
        end
        wr_usedw = 10'd0;
    endtask

    task automatic test_spurious_and_reset();
        cmd_if.burst_done = 1'b1;
        tick();
        cmd_if.burst_done = 1'b0;
        checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL spurious_flag got=%0b exp=1", err_spurious); end
        checks++; if (ring_words !== 11'd1024) begin failures++; $display("FAIL spurious_ring got=%0d exp=1024", ring_words); end
        rd_usedw = 10'd0;
        tick();
        checks++; if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_wr !== 1'b0 || cmd_if.cmd_addr !== 10'd256) begin failures++; $display("FAIL mid_rd_cmd got v=%0b wr=%0b addr=%0d exp v=1 wr=0 addr=256", cmd_if.cmd_valid, cmd_if.cmd_wr, cmd_if.cmd_addr); end
        cmd_if.cmd_ready = 1'b1;
        tick();
        cmd_if.cmd_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cmd_if.cmd_valid !== 1'b0 || cmd_if.cmd_wr !== 1'b0 || cmd_if.cmd_addr !== 10'd0) begin failures++; $display("FAIL busy_reset_cmd got v=%0b wr=%0b addr=%0d exp v=0 wr=0 addr=0", cmd_if.cmd_valid, cmd_if.cmd_wr, cmd_if.cmd_addr); end
        checks++; if (ring_words !== 11'd0 || ring_empty !== 1'b1 || ring_full !== 1'b0 || err_spurious !== 1'b0) begin failures++; $display("FAIL busy_reset_status got words=%0d empty=%0b full=%0b err=%0b exp 0 1 0 0", ring_words, ring_empty, ring_full, err_spurious); end
    endtask

    task automatic test_urgent();
        logic v, w, va;
        logic [ADDR_W-1:0] a;
        logic              exp_w;
        logic [ADDR_W-1:0] exp_a;
        logic [ADDR_W:0]   exp_r;
`ifdef SDRAM_STREAM_WR_URGENT_EN
        exp_w = 1'b1; exp_a = 10'd256; exp_r = 11'd512;
`else
        exp_w = 1'b0; exp_a = 10'd0;   exp_r = 11'd0;
`endif
        wr_usedw = 10'd256;
        rd_usedw = 10'd0;
        grant_burst(v, w, a, va);
        checks++; if (v !== 1'b1 || w !== 1'b1 || a !== 10'd0) begin failures++; $display("FAIL urgent_setup got v=%0b wr=%0b addr=%0d exp v=1 wr=1 addr=0", v, w, a); end
        wr_usedw = 10'd800;
        grant_burst(v, w, a, va);
        wr_usedw = 10'd0;
        checks++; if (v !== 1'b1 || w !== exp_w || a !== exp_a) begin failures++; $display("FAIL urgent_grant got v=%0b wr=%0b addr=%0d exp v=1 wr=%0b addr=%0d", v, w, a, exp_w, exp_a); end
        checks++; if (ring_words !== exp_r) begin failures++; $display("FAIL urgent_ring got=%0d exp=%0d", ring_words, exp_r); end
    endtask

    initial begin
        rst = 1'b1;
        wr_usedw = '0;
        rd_usedw = '0;
        cmd_if.cmd_ready  = 1'b0;
        cmd_if.burst_done = 1'b0;
        test_reset();
        test_first_write();
        test_round_robin();
        test_stall();
        test_wrap_full();
        test_spurious_and_reset();
        test_urgent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
